// File: rtl/dummy_accelerator_pkg.sv
// Shared definitions for the dummy accelerator execution unit.
// Holds the execution-mode type, the X-IF tag layout, the immediate type,
// the pipeline depth ceiling and the iterative FSM state encoding.
package dummy_accelerator_pkg;

  localparam int MaxPipeLength  = 100;
  localparam int XIF_ID_WIDTH   = 4;
  localparam int XIF_ADDR_WIDTH = 5;
  localparam int CONF_WIDTH     = 12;

  typedef enum logic {
    EU_CTL_PIPELINE  = 1'b0,
    EU_CTL_ITERATIVE = 1'b1
  } ctl_type_t;

  typedef logic [CONF_WIDTH-1:0] conf_type_t;

  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0]   id;
    logic [XIF_ADDR_WIDTH-1:0] rd_idx;
  } tag_type_t;

  // Kept as plain constants so older netlists and dumps decode the same way.
  typedef logic [1:0] iter_state_t;
  localparam iter_state_t ITER_IDLE = 2'd0;
  localparam iter_state_t ITER_BUSY = 2'd1;
  localparam iter_state_t ITER_DONE = 2'd2;

endpackage

// File: rtl/dummy_accel_iter_unit.sv
// Blocking multiply-accumulate unit: result = rs1 + N*rs2 (mod 2^XLEN),
// computed by repeated addition over N cycles.
// Ports:
//   clk_i, rst_i, flush_i             : clock, sync active-high reset, kill
//   op_valid/op_ready                 : operation handshake (accept in IDLE only)
//   rs1, rs2, imm, tag                : operands, iteration count N, tag
//   res_valid/res_ready               : result handshake (valid in DONE)
//   result, res_tag                   : accumulator and latched tag
//   busy                              : FSM not IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operation
// BUSY  | adding rs2 into acc, cnt counts remaining additions down
// DONE  | result presented, waiting for the consumer
module dummy_accel_iter_unit
  import dummy_accelerator_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ImmWidth = CONF_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  input  logic [ImmWidth-1:0] imm,
  input  tag_type_t           tag,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [XLEN-1:0]     result,
  output tag_type_t           res_tag,
  output logic                busy
);

  iter_state_t         state;
  logic [XLEN-1:0]     acc;
  logic [XLEN-1:0]     rs2_q;
  logic [ImmWidth-1:0] cnt;
  tag_type_t           tag_q;

  assign op_ready  = (state == ITER_IDLE) && !flush_i;
  assign res_valid = (state == ITER_DONE);
  assign busy      = (state != ITER_IDLE);
  assign result    = acc;
  assign res_tag   = tag_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ITER_IDLE;
      acc   <= '0;
      rs2_q <= '0;
      cnt   <= '0;
      tag_q <= '0;
    end else if (flush_i) begin
      state <= ITER_IDLE;
    end else begin
      case (state)
        ITER_IDLE: begin
          if (op_valid && op_ready) begin
            acc   <= rs1;
            rs2_q <= rs2;
            cnt   <= imm;
            tag_q <= tag;
            state <= (imm == '0) ? ITER_DONE : ITER_BUSY;
          end
        end
        ITER_BUSY: begin
          acc <= acc + rs2_q;
          cnt <= cnt - 1'b1;
          // Terminal count: this is the last addition, cnt becomes 0 now.
          if (cnt == ImmWidth'(1)) state <= ITER_DONE;
        end
        ITER_DONE: begin
          if (res_ready) state <= ITER_IDLE;
        end
        default: state <= ITER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dummy_accel_eu.sv
// Dummy accelerator execution unit on the X-IF issue/result path.
// Pipeline mode: rs1 + rs2 + sext(imm) through PipeDepth register stages.
// Iterative mode: rs1 + imm*rs2 in the iterative sub-unit.
// Results leave strictly in issue order on one valid/ready port.
// Ports:
//   clk_i, rst_i, flush_i            : clock, sync active-high reset, kill
//   issue_valid_i/issue_ready_o      : issue handshake
//   ctl_i, rs1_i, rs2_i, imm_i, tag_i: operation
//   result_valid_o/result_ready_i    : result handshake
//   result_o, tag_o                  : result data and tag (0 when not valid)
//   busy_o                           : any operation in flight
module dummy_accel_eu
  import dummy_accelerator_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ImmWidth  = CONF_WIDTH,
  parameter int XIdWidth  = XIF_ID_WIDTH,
  parameter int AddrWidth = XIF_ADDR_WIDTH,
  parameter int PipeDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  ctl_type_t           ctl_i,
  input  logic [XLEN-1:0]     rs1_i,
  input  logic [XLEN-1:0]     rs2_i,
  input  logic [ImmWidth-1:0] imm_i,
  input  tag_type_t           tag_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [XLEN-1:0]     result_o,
  output tag_type_t           tag_o,
  output logic                busy_o
);

  if (PipeDepth < 1 || PipeDepth > MaxPipeLength) begin : g_bad_depth
    $error("dummy_accel_eu: PipeDepth must be in 1..MaxPipeLength");
  end
  if (XIdWidth != XIF_ID_WIDTH || AddrWidth != XIF_ADDR_WIDTH) begin : g_bad_tag
    $error("dummy_accel_eu: tag widths must match the X-IF package widths");
  end
  if (ImmWidth >= XLEN) begin : g_bad_imm
    $error("dummy_accel_eu: ImmWidth must be narrower than XLEN");
  end

  localparam int Last = PipeDepth - 1;

  logic            stg_valid [PipeDepth];
  logic [XLEN-1:0] stg_data  [PipeDepth];
  tag_type_t       stg_tag   [PipeDepth];

  logic            advance;
  logic            pipe_empty;
  logic            pipe_ready;
  logic            pipe_fire;
  logic [XLEN-1:0] pipe_sum;

  logic            iter_op_valid;
  logic            iter_op_ready;
  logic            iter_ready;
  logic            iter_res_valid;
  logic            iter_res_ready;
  logic [XLEN-1:0] iter_result;
  tag_type_t       iter_tag;
  logic            iter_busy;

  // Global stall: the whole pipeline moves only when the last stage is free
  // or being drained this cycle, so no bubble is ever squeezed out.
  assign advance = !stg_valid[Last] || result_ready_i;

  always_comb begin
    pipe_empty = 1'b1;
    for (int s = 0; s < PipeDepth; s++) begin
      if (stg_valid[s]) pipe_empty = 1'b0;
    end
  end

  // A pipeline op may only enter while the FSM is idle, and an iterative op
  // only once the pipeline has emptied; this keeps results in issue order
  // and guarantees the two result sources never collide.
  assign pipe_ready = !iter_busy && advance && !flush_i;
  assign iter_ready = iter_op_ready && pipe_empty;

  always_comb begin
    issue_ready_o = (ctl_i == EU_CTL_ITERATIVE) ? iter_ready : pipe_ready;
  end

  assign pipe_fire     = issue_valid_i && (ctl_i == EU_CTL_PIPELINE) && pipe_ready;
  assign iter_op_valid = issue_valid_i && (ctl_i == EU_CTL_ITERATIVE) && pipe_empty;

  assign pipe_sum = rs1_i + rs2_i + {{(XLEN-ImmWidth){imm_i[ImmWidth-1]}}, imm_i};

  for (genvar s = 0; s < PipeDepth; s++) begin : g_stage
    logic            in_valid;
    logic [XLEN-1:0] in_data;
    tag_type_t       in_tag;

    if (s == 0) begin : g_head
      assign in_valid = pipe_fire;
      assign in_data  = pipe_sum;
      assign in_tag   = tag_i;
    end else begin : g_body
      assign in_valid = stg_valid[s-1];
      assign in_data  = stg_data[s-1];
      assign in_tag   = stg_tag[s-1];
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stg_valid[s] <= 1'b0;
        stg_data[s]  <= '0;
        stg_tag[s]   <= '0;
      end else if (flush_i) begin
        stg_valid[s] <= 1'b0;
      end else if (advance) begin
        stg_valid[s] <= in_valid;
        stg_data[s]  <= in_data;
        stg_tag[s]   <= in_tag;
      end
    end
  end

  assign iter_res_ready = result_ready_i && !stg_valid[Last];

  dummy_accel_iter_unit #(
    .XLEN     (XLEN),
    .ImmWidth (ImmWidth)
  ) u_iter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .op_valid  (iter_op_valid),
    .op_ready  (iter_op_ready),
    .rs1       (rs1_i),
    .rs2       (rs2_i),
    .imm       (imm_i),
    .tag       (tag_i),
    .res_valid (iter_res_valid),
    .res_ready (iter_res_ready),
    .result    (iter_result),
    .res_tag   (iter_tag),
    .busy      (iter_busy)
  );

  always_comb begin
    result_valid_o = 1'b0;
    result_o       = '0;
    tag_o          = '0;
    if (stg_valid[Last]) begin
      result_valid_o = 1'b1;
      result_o       = stg_data[Last];
      tag_o          = stg_tag[Last];
    end else if (iter_res_valid) begin
      result_valid_o = 1'b1;
      result_o       = iter_result;
      tag_o          = iter_tag;
    end
  end

  assign busy_o = !pipe_empty || iter_busy;

endmodule

// File: tb/tb_dummy_accel_eu.sv
module tb_dummy_accel_eu;
  import dummy_accelerator_pkg::*;

  localparam int PIPE_DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  ctl_type_t   ctl_i = EU_CTL_PIPELINE;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [11:0] imm_i = '0;
  tag_type_t   tag_i = '0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b1;
  logic [31:0] result_o;
  tag_type_t   tag_o;
  logic        busy_o;

  dummy_accel_eu #(
    .XLEN(32), .ImmWidth(12), .XIdWidth(4), .AddrWidth(5), .PipeDepth(PIPE_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .ctl_i(ctl_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .tag_i(tag_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_o(result_o), .tag_o(tag_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    tag_type_t   tag;
    int          acc_cyc;
    bit          iter;
    int          n;
  } exp_t;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];
  int          acc_log[$];
  int          n_pushed = 0;
  int          n_popped = 0;
  int          last_acc = 0;
  int          last_start = 0;
  int          last_hs = 0;
  logic [31:0] last_res = '0;
  tag_type_t   last_tag = '0;
  bit          rand_mode = 0;
  int          pres_start = 0;
  bit          prev_v = 0;
  bit          prev_hs = 0;
  logic [31:0] prev_res = '0;
  tag_type_t   prev_tag = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail_msg(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  // Reference: arithmetic straight from the operation definitions.
  function automatic logic [31:0] ref_model(input ctl_type_t c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [11:0] im);
    longint sa = longint'(a);
    longint sb = longint'(b);
    longint si;
    if (c == EU_CTL_PIPELINE) begin
      si = (im >= 12'h800) ? longint'(im) - 4096 : longint'(im);
      return 32'(sa + sb + si);
    end
    return 32'(sa + longint'(im) * sb);
  endfunction

  // Scoreboard monitor: pushes on accepted issue, pops on result handshake.
  always @(negedge clk_i) begin
    exp_t e;
    int   lat;
    if (rst_i) begin
      sb_q.delete();
      prev_v = 0;
    end else begin
      if (result_valid_o) begin
        if (prev_v && !prev_hs) begin
          chk("hold_data", 64'(result_o), 64'(prev_res));
          chk("hold_tag", 64'(tag_o), 64'(prev_tag));
        end else begin
          pres_start = cyc;
        end
        if (result_ready_i) begin
          if (sb_q.size() == 0) begin
            chk("spurious_result", 64'(1), 64'(0));
          end else begin
            e = sb_q.pop_front();
            chk("sb_result", 64'(result_o), 64'(e.res));
            chk("sb_tag", 64'(tag_o), 64'(e.tag));
            lat = pres_start - e.acc_cyc;
            if (e.iter) chk("iter_latency", 64'(lat), 64'(e.n + 1));
            else chk("pipe_latency_min", 64'(lat >= PIPE_DEPTH), 64'(1));
            n_popped++;
            last_acc   = e.acc_cyc;
            last_start = pres_start;
            last_hs    = cyc;
            last_res   = result_o;
            last_tag   = tag_o;
          end
        end
      end else begin
        chk("idle_outputs_zero", {32'(result_o), 32'(tag_o)}, 64'(0));
      end
      prev_v   = result_valid_o;
      prev_hs  = result_valid_o && result_ready_i;
      prev_res = result_o;
      prev_tag = tag_o;
      if (flush_i) begin
        chk("flush_ready_low", 64'(issue_ready_o), 64'(0));
        sb_q.delete();
        prev_v = 0;
      end else if (issue_valid_i && issue_ready_o) begin
        e.res     = ref_model(ctl_i, rs1_i, rs2_i, imm_i);
        e.tag     = tag_i;
        e.acc_cyc = cyc;
        e.iter    = (ctl_i == EU_CTL_ITERATIVE);
        e.n       = int'(imm_i);
        sb_q.push_back(e);
        acc_log.push_back(cyc);
        n_pushed++;
      end
    end
  end

  // Random consumer back-pressure and occasional flush during the random phase.
  initial forever begin
    @(posedge clk_i);
    #1;
    if (rand_mode) begin
      result_ready_i = ($urandom_range(0, 3) != 0);
      flush_i        = ($urandom_range(0, 59) == 0);
    end
  end

  // All tasks are entered and left at posedge+1.
  task automatic do_issue(input ctl_type_t c, input logic [31:0] a, input logic [31:0] b,
                          input logic [11:0] im, input tag_type_t tg, input int budget);
    bit ok = 0;
    ctl_i = c; rs1_i = a; rs2_i = b; imm_i = im; tag_i = tg;
    issue_valid_i = 1'b1;
    for (int w = 0; w < budget && !ok; w++) begin
      @(negedge clk_i);
      if (issue_ready_o && !flush_i) ok = 1;
      @(posedge clk_i);
      #1;
    end
    issue_valid_i = 1'b0;
    if (!ok) fail_msg("issue_timeout");
  endtask

  task automatic drain(input int budget, input string nm);
    int w = 0;
    while (sb_q.size() != 0 && w < budget) begin
      @(posedge clk_i);
      #1;
      w++;
    end
    if (sb_q.size() != 0) fail_msg(nm);
  endtask

  task automatic watch_quiet(input int n, output bit saw);
    saw = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (result_valid_o) saw = 1;
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    int t0, base, pbase;
    bit saw;
    tag_type_t tg;
    ctl_type_t c;
    logic [11:0] im;

    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("rst_ready", 64'(issue_ready_o), 64'(1));
    chk("rst_valid", 64'(result_valid_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", 64'(issue_ready_o), 64'(1));
    chk("post_rst_outputs", {32'(result_o), 32'(tag_o)}, 64'(0));
    chk("post_rst_busy", 64'(busy_o), 64'(0));
    @(posedge clk_i);
    #1;

    // Single pipeline op, no stall.
    tg.id = 4'd3; tg.rd_idx = 5'd7;
    do_issue(EU_CTL_PIPELINE, 32'd10, 32'd20, 12'hFFF, tg, 5);
    drain(20, "p1_drain");
    chk("p1_result", 64'(last_res), 64'd29);
    chk("p1_tag", 64'(last_tag), 64'({4'd3, 5'd7}));
    chk("p1_latency", 64'(last_start - last_acc), 64'(PIPE_DEPTH));

    // Five back-to-back ops with a 3-cycle consumer stall.
    base  = acc_log.size();
    pbase = n_popped;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          tg = tag_type_t'(9'(16 + i));
          do_issue(EU_CTL_PIPELINE, 32'(100 * i), 32'(i), 12'(i), tg, 20);
        end
      end
      begin
        for (int w = 0; w < 20 && acc_log.size() <= base; w++) @(posedge clk_i);
        t0 = acc_log[base];
        while (cyc < t0 + 4) begin
          @(posedge clk_i);
          #1;
        end
        result_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk_i);
          chk("stall_issue_ready", 64'(issue_ready_o), 64'(0));
          @(posedge clk_i);
          #1;
        end
        result_ready_i = 1'b1;
      end
    join
    drain(40, "b2b_drain");
    chk("b2b_count", 64'(n_popped - pbase), 64'(5));

    // Iterative cases.
    do_issue(EU_CTL_ITERATIVE, 32'd5, 32'd3, 12'd4, tag_type_t'(9'h21), 5);
    drain(20, "it1_drain");
    chk("it1_result", 64'(last_res), 64'd17);
    chk("it1_latency", 64'(last_start - last_acc), 64'd5);
    do_issue(EU_CTL_ITERATIVE, 32'd5, 32'd3, 12'd0, tag_type_t'(9'h22), 5);
    drain(20, "it0_drain");
    chk("it0_result", 64'(last_res), 64'd5);
    chk("it0_latency", 64'(last_start - last_acc), 64'd1);
    do_issue(EU_CTL_ITERATIVE, 32'hFFFF_FFFF, 32'd1, 12'd2, tag_type_t'(9'h23), 5);
    drain(20, "itw_drain");
    chk("itwrap_result", 64'(last_res), 64'd1);
    do_issue(EU_CTL_ITERATIVE, 32'd1, 32'd1, 12'hFFF, tag_type_t'(9'h24), 5);
    drain(4200, "itmax_drain");
    chk("itmax_result", 64'(last_res), 64'd4096);
    chk("itmax_latency", 64'(last_start - last_acc), 64'd4096);

    // Pipeline in flight blocks an iterative op until its result handshakes.
    result_ready_i = 1'b0;
    do_issue(EU_CTL_PIPELINE, 32'd1, 32'd2, 12'd3, tag_type_t'(9'h31), 5);
    ctl_i = EU_CTL_ITERATIVE; rs1_i = 32'd9; rs2_i = 32'd4; imm_i = 12'd2;
    tag_i = tag_type_t'(9'h32);
    issue_valid_i = 1'b1;
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (issue_ready_o) saw = 1;
      @(posedge clk_i);
      #1;
    end
    chk("iter_blocked_by_pipe", 64'(saw), 64'(0));
    result_ready_i = 1'b1;
    do_issue(EU_CTL_ITERATIVE, 32'd9, 32'd4, 12'd2, tag_type_t'(9'h32), 10);
    chk("iter_after_hs", 64'(last_acc == 0 ? 0 : acc_log[acc_log.size()-1] - last_hs), 64'd1);
    drain(20, "mix_drain");
    chk("mix_result", 64'(last_res), 64'd17);

    // Flush a long iterative op.
    do_issue(EU_CTL_ITERATIVE, 32'd0, 32'd1, 12'd100, tag_type_t'(9'h41), 5);
    t0 = acc_log[acc_log.size()-1];
    while (cyc < t0 + 10) begin
      @(posedge clk_i);
      #1;
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("pre_flush_busy", 64'(busy_o), 64'(1));
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("post_flush_busy", 64'(busy_o), 64'(0));
    chk("post_flush_valid", 64'(result_valid_o), 64'(0));
    @(posedge clk_i);
    #1;
    watch_quiet(110, saw);
    chk("flush_no_result", 64'(saw), 64'(0));
    do_issue(EU_CTL_ITERATIVE, 32'd7, 32'd2, 12'd3, tag_type_t'(9'h42), 5);
    drain(20, "after_flush_drain");
    chk("after_flush_result", 64'(last_res), 64'd13);

    // Issue together with flush is dropped.
    base = n_pushed;
    ctl_i = EU_CTL_PIPELINE; rs1_i = 32'd1; rs2_i = 32'd1; imm_i = 12'd1;
    issue_valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    issue_valid_i = 1'b0;
    flush_i = 1'b0;
    watch_quiet(10, saw);
    chk("flush_issue_dropped", 64'(saw), 64'(0));
    chk("flush_issue_not_pushed", 64'(n_pushed - base), 64'(0));

    // Reset mid-pipeline.
    result_ready_i = 1'b0;
    do_issue(EU_CTL_PIPELINE, 32'd5, 32'd6, 12'd7, tag_type_t'(9'h51), 5);
    do_issue(EU_CTL_PIPELINE, 32'd8, 32'd9, 12'd1, tag_type_t'(9'h52), 5);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("midrst_valid", 64'(result_valid_o), 64'(0));
    chk("midrst_outputs", {32'(result_o), 32'(tag_o)}, 64'(0));
    chk("midrst_busy", 64'(busy_o), 64'(0));
    chk("midrst_ready", 64'(issue_ready_o), 64'(1));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    result_ready_i = 1'b1;
    watch_quiet(8, saw);
    chk("midrst_no_result", 64'(saw), 64'(0));

    // Randomized mix with back-pressure and occasional flush.
    rand_mode = 1;
    for (int i = 0; i < 300; i++) begin
      c  = ($urandom_range(0, 9) < 7) ? EU_CTL_PIPELINE : EU_CTL_ITERATIVE;
      im = (c == EU_CTL_PIPELINE) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 15));
      tg = tag_type_t'(9'($urandom_range(0, 511)));
      do_issue(c, 32'($urandom), 32'($urandom), im, tg, 300);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
    end
    rand_mode = 0;
    result_ready_i = 1'b1;
    flush_i = 1'b0;
    drain(500, "final_drain");
    @(negedge clk_i);
    chk("final_busy", 64'(busy_o), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dummy_accel_eu.md
# dummy_accel_eu

- Parametrised execution unit for the dummy accelerator, behind the core's eXtension interface (X-IF) issue/result path.
- Executes both dummy instruction classes:
  - `EU_CTL_PIPELINE`: fully pipelined add, configurable depth.
  - `EU_CTL_ITERATIVE`: blocking multi-cycle multiply-accumulate, length set by the immediate.
- Carries an `{id, rd_idx}` tag per operation and returns results strictly in issue order through one valid/ready port.
- Supports flush.

## Interface

Parameters:
- `XLEN`, 32: operand/result width.
- `ImmWidth`, 12: immediate (`conf_type_t`) width.
- `XIdWidth`, 4: X-IF instruction id width.
- `AddrWidth`, 5: destination register index width.
- `PipeDepth`, 4: pipeline-mode latency in stages; legal range 1..`MaxPipeLength` (100), checked by elaboration assertion.

Ports:
- `clk_i` in 1: clock. One clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous active-high reset.
- `flush_i` in 1: synchronous kill of all in-flight operations.
- `issue_valid_i` in 1: operation offered.
- `issue_ready_o` out 1: operation accepted when high together with `issue_valid_i`.
- `ctl_i` in `ctl_type_t`: execution mode.
- `rs1_i` in XLEN: source operand 1.
- `rs2_i` in XLEN: source operand 2.
- `imm_i` in ImmWidth: immediate / iteration count.
- `tag_i` in `tag_type_t`: `{id, rd_idx}`.
- `result_valid_o` out 1: result available.
- `result_ready_i` in 1: consumer takes the result.
- `result_o` out XLEN: result data.
- `tag_o` out `tag_type_t`: tag of the returned result.
- `busy_o` out 1: any operation in flight (pipeline slot valid or FSM not IDLE).

## Operation

- Pipeline result: `rs1 + rs2 + sext(imm)`, modulo 2^XLEN.
- Iterative result: `rs1 + N*rs2`, modulo 2^XLEN, with N = `imm_i` as unsigned. N = 0 returns `rs1`.
- Pipeline: `PipeDepth` register stages, each holding {valid, data, tag}; the last stage drives the output.
  - `advance = !last_valid || result_ready_i`. All stages shift together on `advance`; when it is low, the whole pipeline holds (global stall, no bubbles collapsed).
- Iterative FSM (states IDLE, BUSY, DONE):
  - IDLE → accept: acc=`rs1`, cnt=N, latch `rs2` and tag. Next state is BUSY if N≠0, else DONE.
  - BUSY: each cycle acc+=rs2 and cnt−=1. Move to DONE when cnt reaches 0 (the cycle it becomes 0).
  - DONE: drives output. On `result_ready_i` → IDLE.
- Issue acceptance, which guarantees in-order, conflict-free output:
  - Pipeline op: ready = FSM IDLE && `advance`.
  - Iterative op: ready = FSM IDLE && no pipeline stage valid.
  - `issue_ready_o` may depend combinationally on `ctl_i` and `result_ready_i`. It never depends on `issue_valid_i`.
- Output mux: last pipeline stage if valid, else FSM DONE. Both are never valid at once. When not valid, `result_o` and `tag_o` are 0.
- Flush: `flush_i` clears all stage valid bits and forces the FSM to IDLE. An issue in the same cycle is discarded, and `issue_ready_o` is 0 while `flush_i` is high.
- Priority: `rst_i` > `flush_i` > normal operation.

## Timing

- Reset values: `issue_ready_o`=1 (combinational from idle state), `result_valid_o`=0, `result_o`=0, `tag_o`=0, `busy_o`=0. Accumulator, counter and stage data are also 0.
- Pipeline latency: accept at cycle t → `result_valid_o` at t+`PipeDepth`, provided no stall occurs. Throughput is 1 op/cycle.
- Iterative latency: accept at t → `result_valid_o` at t+1+N. With N=4095, the result appears at t+4096.
- Output stability: while `result_valid_o`=1 and `result_ready_i`=0, data and tag hold stable until the handshake.
- Handshake and re-issue: result handshake in cycle t (DONE → IDLE) → a new op can be accepted at t+1, not at t.
- Last-stage drain and refill: the last stage can drain while stage 0 refills in the same cycle. This is back-to-back with no bubble.
- Switching pipeline → iterative: the iterative op waits until the last pipeline result has handshaken.

## Structure

- `dummy_accelerator_pkg` holds the shared definitions: `ctl_type_t`, `tag_type_t`, `conf_type_t`, `MaxPipeLength`, and the X-IF widths. Add the FSM state enum `iter_state_t` there as well.
- Sub-module `dummy_accel_iter_unit` contains the FSM, accumulator, counter, latched `rs2` and tag, with its own valid/ready on both sides.
- The pipeline uses a generate loop of stages in the top level.

## Test plan

- PipeDepth=4: issue pipeline rs1=10, rs2=20, imm=0xFFF, tag {3,7} at t, ready held high → result 29, tag {3,7} valid at t+4.
- Pipeline, 5 back-to-back ops with `result_ready_i` low for cycles t+4..t+6 → all 5 results in order, none lost or duplicated. `issue_ready_o`=0 during the stall.
- Iterative rs1=5, rs2=3, imm=4 → result 17 at t+5. Iterative imm=0 → result 5 at t+1. rs1=0xFFFFFFFF, rs2=1, imm=2 → result 1 (wrap).
- Pipeline op in flight, then iterative offered → `issue_ready_o`=0 until the pipeline result handshakes; the iterative op is accepted the next cycle.
- Iterative imm=100 running, `flush_i` at cycle 10 → no `result_valid_o`, `busy_o`=0 the next cycle, and the next op executes correctly. `rst_i` mid-pipeline → all outputs return to reset values.
- Simultaneous `issue_valid_i` and `flush_i` → op is dropped, no result ever produced.
